// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle arith/logic ops and iterative signed multiply/divide.
// Define ALU_SEQ_DIV_EN to build the restoring divider and enable opcode 0101.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Upper,
  output logic [WIDTH-1:0] Lower,
  output logic             Zero,
  output logic             Ovf,
  output logic             DivZero,
  output logic             Illegal
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0111;
  localparam logic [3:0] OP_SWP = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1011;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b0101;
`endif

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_dbl(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    last_step;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum, diff;
  logic [WIDTH-1:0]        sc_hi, sc_lo;
  logic                    sc_ovf, sc_dz, sc_ill, sc_multi;
  logic [WIDTH:0]          acc_hi, mul_sum, step_hi;
  logic [WIDTH-1:0]        acc_lo, step_lo, mag_op;
  logic                    sign_a, sign_b;
  logic [2*WIDTH-1:0]      fix_res;
  logic                    res_load, res_ovf, res_dz, res_ill;
  logic [WIDTH-1:0]        res_hi, res_lo;
`ifdef ALU_SEQ_DIV_EN
  logic                    is_div;
  logic [WIDTH:0]          div_shift, div_trial;
`endif

  assign a_s       = Data1;
  assign b_s       = Data2;
  assign busy      = (state == ITER);
  assign done      = (state == DONE);
  assign last_step = (cnt == CNT_LAST);

  always_comb begin
    sum      = Data1 + Data2;
    diff     = Data1 - Data2;
    sc_hi    = '0;
    sc_lo    = '0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    sc_ill   = 1'b0;
    sc_multi = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        sc_lo  = sum;
        sc_ovf = (Data1[WIDTH-1] == Data2[WIDTH-1]) && (sum[WIDTH-1] != Data1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo  = diff;
        sc_ovf = (Data1[WIDTH-1] != Data2[WIDTH-1]) && (diff[WIDTH-1] != Data1[WIDTH-1]);
      end
      OP_MUL: sc_multi = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        // Divide by zero never enters the iteration loop
        if (Data2 == '0) begin
          sc_lo = '1;
          sc_hi = Data1;
          sc_dz = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
`endif
      OP_MOV: sc_lo = Data2;
      OP_SWP: begin
        sc_lo = Data2;
        sc_hi = Data1;
      end
      OP_AND:  sc_lo = Data1 & Data2;
      OP_OR:   sc_lo = Data1 | Data2;
      default: sc_ill = 1'b1;
    endcase
  end

  // Iteration step: shift-add multiply on {acc_hi,acc_lo}, or restoring divide with acc_hi as remainder
  always_comb begin
    mul_sum = acc_hi + (acc_lo[0] ? {1'b0, mag_op} : '0);
    step_hi = {1'b0, mul_sum[WIDTH:1]};
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_op};
    if (is_div) begin
      step_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      step_hi = div_trial[WIDTH] ? div_shift : div_trial;
    end
`endif
  end

  always_comb begin
    fix_res = cond_neg_dbl({step_hi[WIDTH-1:0], step_lo}, sign_a ^ sign_b);
`ifdef ALU_SEQ_DIV_EN
    // Remainder follows the dividend sign; most-negative / -1 wraps naturally
    if (is_div)
      fix_res = {cond_neg(step_hi[WIDTH-1:0], sign_a), cond_neg(step_lo, sign_a ^ sign_b)};
`endif
  end

  always_comb begin
    state_nxt = state;
    res_load  = 1'b0;
    res_hi    = sc_hi;
    res_lo    = sc_lo;
    res_ovf   = sc_ovf;
    res_dz    = sc_dz;
    res_ill   = sc_ill;
    case (state)
      IDLE: begin
        if (start) begin
          if (sc_multi) begin
            state_nxt = ITER;
          end else begin
            state_nxt = DONE;
            res_load  = 1'b1;
          end
        end
      end
      ITER: begin
        if (last_step) begin
          state_nxt        = DONE;
          res_load         = 1'b1;
          {res_hi, res_lo} = fix_res;
          res_ovf          = 1'b0;
          res_dz           = 1'b0;
          res_ill          = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      Upper   <= '0;
      Lower   <= '0;
      Zero    <= 1'b0;
      Ovf     <= 1'b0;
      DivZero <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ITER) ? cnt + CNT_W'(1) : '0;
      if (res_load) begin
        Upper   <= res_hi;
        Lower   <= res_lo;
        Zero    <= ({res_hi, res_lo} == '0);
        Ovf     <= res_ovf;
        DivZero <= res_dz;
        Illegal <= res_ill;
      end
    end
  end

  // Iteration datapath: magnitudes latched at start, accumulator advanced each ITER cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && start && sc_multi) begin
      acc_hi <= '0;
      sign_a <= Data1[WIDTH-1];
      sign_b <= Data2[WIDTH-1];
      acc_lo <= abs_val(b_s);
      mag_op <= abs_val(a_s);
`ifdef ALU_SEQ_DIV_EN
      is_div <= (ALUOp == OP_DIV);
      if (ALUOp == OP_DIV) begin
        acc_lo <= abs_val(a_s);
        mag_op <= abs_val(b_s);
      end
`endif
    end else if (state == ITER) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16); div vectors follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
  localparam int W = 16;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, MUL = 4'b0100, DIV = 4'b0101;
  localparam logic [3:0] MOV = 4'b0111, SWP = 4'b1000, AND_ = 4'b1001, OR_ = 4'b1011;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   ALUOp;
  logic [W-1:0] Data1, Data2;
  logic         busy, done, Zero, Ovf, DivZero, Illegal;
  logic [W-1:0] Upper, Lower;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .Data1(Data1), .Data2(Data2),
    .busy(busy), .done(done), .Upper(Upper), .Lower(Lower), .Zero(Zero), .Ovf(Ovf),
    .DivZero(DivZero), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op and return at the negedge of the cycle in which done is seen.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    ALUOp = op; Data1 = a; Data2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_lat, input logic [31:0] exp_ul,
                       input logic [3:0] exp_fl);
    int lat, bc;
    run_op(op, a, b, lat, bc);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, bc, exp_lat - 1);
    check({tag, "_res"}, {Upper, Lower}, exp_ul);
    check({tag, "_flags"}, {busy, Zero, Ovf, DivZero, Illegal}, {1'b0, exp_fl});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, n_done;
    rst = 1'b1; start = 1'b0; ALUOp = '0; Data1 = '0; Data2 = '0;
    repeat (3) @(negedge clk);
    check("reset", {busy, done, Zero, Ovf, DivZero, Illegal, Upper, Lower}, '0);
    rst = 1'b0;

    // flags order: {Zero, Ovf, DivZero, Illegal}
    do_op("add_ovf", ADD, 16'h7FFF, 16'h0001, 1, 32'h0000_8000, 4'b0100);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("hold", {Upper, Lower, Ovf}, {32'h0000_8000, 1'b1});

    do_op("mul_neg", MUL, 16'hFFFD, 16'h0007, 17, 32'hFFFF_FFEB, 4'b0000);
    do_op("sub_ovf", SUB, 16'h8000, 16'h0001, 1, 32'h0000_7FFF, 4'b0100);
    do_op("sub", SUB, 16'h0005, 16'h0003, 1, 32'h0000_0002, 4'b0000);
    do_op("swap", SWP, 16'h1234, 16'hABCD, 1, 32'h1234_ABCD, 4'b0000);
    do_op("and", AND_, 16'hF0F0, 16'h3C3C, 1, 32'h0000_3030, 4'b0000);
    do_op("or", OR_, 16'hF0F0, 16'h0F0F, 1, 32'h0000_FFFF, 4'b0000);
    do_op("move0", MOV, 16'h5555, 16'h0000, 1, 32'h0000_0000, 4'b1000);
    do_op("illegal", 4'b1111, 16'h1111, 16'h2222, 1, 32'h0000_0000, 4'b1001);
    do_op("mul_minmin", MUL, 16'h8000, 16'h8000, 17, 32'h4000_0000, 4'b0000);
    do_op("mul_maxmax", MUL, 16'h7FFF, 16'h7FFF, 17, 32'h3FFF_0001, 4'b0000);
    do_op("mul_zero", MUL, 16'h0000, 16'h0005, 17, 32'h0000_0000, 4'b1000);
    do_op("b2b_add", ADD, 16'h0001, 16'h0002, 1, 32'h0000_0003, 4'b0000);

`ifdef ALU_SEQ_DIV_EN
    do_op("div_neg", DIV, 16'hFFF9, 16'h0002, 17, 32'hFFFF_FFFD, 4'b0000);
    do_op("div_zero", DIV, 16'h0005, 16'h0000, 1, 32'h0005_FFFF, 4'b0010);
    do_op("div_minm1", DIV, 16'h8000, 16'hFFFF, 17, 32'h0000_8000, 4'b0000);
    do_op("div_negb", DIV, 16'h0007, 16'hFFFE, 17, 32'h0001_FFFD, 4'b0000);
`else
    do_op("div_off", DIV, 16'h000A, 16'h0002, 1, 32'h0000_0000, 4'b1001);
`endif

    // start held into the DONE cycle must not launch a second op
    @(negedge clk);
    ALUOp = ADD; Data1 = 16'h0002; Data2 = 16'h0002; start = 1'b1;
    @(negedge clk);
    check("held_done", {done, Lower}, {1'b1, 16'h0004});
    @(negedge clk);
    start = 1'b0;
    check("held_idle", done, 1'b0);
    @(negedge clk);
    check("held_no_redo", done, 1'b0);

    // add pulsed while a mul is busy is ignored
    @(negedge clk);
    ALUOp = MUL; Data1 = 16'h0003; Data2 = 16'h0004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    ALUOp = ADD; Data1 = 16'h0001; Data2 = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 6;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy_ign_lat", lat, 17);
    check("busy_ign_res", {Upper, Lower}, 32'h0000_000C);
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("busy_ign_nodone", n_done, 0);

    // reset at ITER step 8 aborts the mul
    @(negedge clk);
    ALUOp = MUL; Data1 = 16'h0003; Data2 = 16'h0005; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", {busy, done, Zero, Ovf, DivZero, Illegal, Upper, Lower}, '0);
    rst = 1'b0;
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst_no_done", n_done, 0);

    do_op("post_rst", ADD, 16'hFFFF, 16'h0001, 1, 32'h0000_0000, 4'b1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
